// File: rtl/direct_message_channel.sv
// direct_message_channel: an order-preserving FIFO that carries direct messages
// [receiver, is_odd_cardinality_root, is_touching_boundary] between two
// processing units. It also tracks occupancy, a high-water mark and sticky
// overflow/underflow flags.
//
// Handshake: the sender pushes on any edge where in_valid=1 and in_is_full=0.
// The receiver pops on any edge where out_is_taken=1 and out_valid=1.
// in_is_full depends only on the stored count, so a pop in the same cycle never
// frees a slot for a push. out_data is first-word fall-through and is only
// meaningful while out_valid=1.
module direct_message_channel #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DEPTH         = 4,
  parameter int MSG_WIDTH     = ADDRESS_WIDTH + 2,
  parameter int COUNT_WIDTH   = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [MSG_WIDTH-1:0]   in_data,
  input  logic                   in_valid,
  output logic                   in_is_full,
  output logic [MSG_WIDTH-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_is_taken,
  output logic [COUNT_WIDTH-1:0] occupancy,
  output logic [COUNT_WIDTH-1:0] max_occupancy,
  output logic                   overflow_error,
  output logic                   underflow_error
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(DEPTH);

  logic [MSG_WIDTH-1:0]   mem [DEPTH];
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [COUNT_WIDTH-1:0] count;
  logic [COUNT_WIDTH-1:0] count_next;
  logic                   push;
  logic                   pop;

  assign in_is_full = (count == FULL_COUNT);
  assign out_valid  = (count != '0);
  assign out_data   = mem[rd_ptr];
  assign occupancy  = count;

  // Accepted transfers; flush discards anything offered in its cycle.
  assign push = in_valid & ~in_is_full & ~flush;
  assign pop  = out_is_taken & out_valid & ~flush;

  // Next stored count, also used to update the watermark.
  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + COUNT_WIDTH'(1);
    end else if (pop && !push) begin
      count_next = count - COUNT_WIDTH'(1);
    end
  end

  // Message storage; contents are not reset, only pointers/count are.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers, count, watermark and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      max_occupancy   <= '0;
      overflow_error  <= 1'b0;
      underflow_error <= 1'b0;
    end else if (flush) begin
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      max_occupancy   <= '0;
      overflow_error  <= 1'b0;
      underflow_error <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      end
      count <= count_next;
      if (count_next > max_occupancy) begin
        max_occupancy <= count_next;
      end
      if (in_valid && in_is_full) begin
        overflow_error <= 1'b1;
      end
      if (out_is_taken && !out_valid) begin
        underflow_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_direct_message_channel.sv
// Directed testbench for direct_message_channel (DEPTH=4, 10-bit messages).
// Inputs change 1 ns after each rising edge; outputs are checked at that point.
module tb_direct_message_channel;

  localparam int ADDRESS_WIDTH = 8;
  localparam int DEPTH         = 4;
  localparam int MSG_WIDTH     = ADDRESS_WIDTH + 2;
  localparam int COUNT_WIDTH   = $clog2(DEPTH + 1);

  logic                   clk;
  logic                   reset;
  logic                   flush;
  logic [MSG_WIDTH-1:0]   in_data;
  logic                   in_valid;
  logic                   in_is_full;
  logic [MSG_WIDTH-1:0]   out_data;
  logic                   out_valid;
  logic                   out_is_taken;
  logic [COUNT_WIDTH-1:0] occupancy;
  logic [COUNT_WIDTH-1:0] max_occupancy;
  logic                   overflow_error;
  logic                   underflow_error;

  int vectors;
  int miscompares;

  direct_message_channel #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_is_full(in_is_full),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_is_taken(out_is_taken),
    .occupancy(occupancy),
    .max_occupancy(max_occupancy),
    .overflow_error(overflow_error),
    .underflow_error(underflow_error)
  );

  // Clock: 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 0);
    check({tag, " in_is_full"}, 32'(in_is_full), 0);
    check({tag, " occupancy"}, 32'(occupancy), 0);
    check({tag, " overflow"}, 32'(overflow_error), 0);
    check({tag, " underflow"}, 32'(underflow_error), 0);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b1;
    flush        = 1'b0;
    in_data      = '0;
    in_valid     = 1'b0;
    out_is_taken = 1'b0;

    // Reset held for 10 cycles, then idle for 5.
    for (int i = 0; i < 10; i++) begin
      step();
      check_idle("reset");
    end
    check("reset max_occ", 32'(max_occupancy), 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_idle("idle");
    end

    // Fill with four messages.
    in_valid = 1'b1;
    in_data = 10'h3A1; step();
    check("fill1 occ", 32'(occupancy), 1);
    check("fill1 valid", 32'(out_valid), 1);
    check("fill1 data", 32'(out_data), 32'h3A1);
    in_data = 10'h0F2; step();
    check("fill2 occ", 32'(occupancy), 2);
    in_data = 10'h155; step();
    check("fill3 occ", 32'(occupancy), 3);
    check("fill3 not full", 32'(in_is_full), 0);
    in_data = 10'h2AB; step();
    in_valid = 1'b0;
    check("fill4 full", 32'(in_is_full), 1);
    check("fill4 occ", 32'(occupancy), 4);
    check("fill4 max_occ", 32'(max_occupancy), 4);
    check("fill4 data", 32'(out_data), 32'h3A1);

    // Drain in order.
    out_is_taken = 1'b1;
    check("drain d0", 32'(out_data), 32'h3A1);
    step();
    check("drain not full", 32'(in_is_full), 0);
    check("drain d1", 32'(out_data), 32'h0F2);
    step();
    check("drain d2", 32'(out_data), 32'h155);
    step();
    check("drain d3", 32'(out_data), 32'h2AB);
    step();
    out_is_taken = 1'b0;
    check("drain empty", 32'(out_valid), 0);
    check("drain occ", 32'(occupancy), 0);
    check("drain no underflow", 32'(underflow_error), 0);
    check("drain max_occ", 32'(max_occupancy), 4);

    // Refill, then push+pop while full: only the pop takes effect.
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = MSG_WIDTH'(i);
      step();
    end
    check("refill full", 32'(in_is_full), 1);
    check("refill no overflow", 32'(overflow_error), 0);
    in_data = 10'h111;
    out_is_taken = 1'b1;
    step();
    in_valid = 1'b0;
    out_is_taken = 1'b0;
    check("ovf occ", 32'(occupancy), 3);
    check("ovf flag", 32'(overflow_error), 1);
    check("ovf not full", 32'(in_is_full), 0);
    out_is_taken = 1'b1;
    check("ovf d0", 32'(out_data), 32'h002);
    step();
    check("ovf d1", 32'(out_data), 32'h003);
    step();
    check("ovf d2", 32'(out_data), 32'h004);
    step();
    out_is_taken = 1'b0;
    check("ovf empty", 32'(out_valid), 0);

    // Streaming through several pointer wraps with one word preloaded.
    in_valid = 1'b1;
    in_data = 10'h200;
    step();
    for (int i = 0; i < 20; i++) begin
      in_data = MSG_WIDTH'(32'h201 + i);
      out_is_taken = 1'b1;
      check("stream data", 32'(out_data), 32'h200 + i);
      step();
      check("stream occ", 32'(occupancy), 1);
    end
    in_valid = 1'b0;
    check("stream last", 32'(out_data), 32'h214);
    step();
    out_is_taken = 1'b0;
    check("stream empty", 32'(out_valid), 0);
    check("stream ovf sticky", 32'(overflow_error), 1);
    check("stream max_occ", 32'(max_occupancy), 4);

    // Underflow, then flush with a simultaneous push.
    out_is_taken = 1'b1;
    step();
    out_is_taken = 1'b0;
    check("udf flag", 32'(underflow_error), 1);
    check("udf occ", 32'(occupancy), 0);
    in_valid = 1'b1;
    in_data = 10'h0AA; step();
    in_data = 10'h0BB; step();
    check("pre-flush occ", 32'(occupancy), 2);
    flush = 1'b1;
    in_data = 10'h0CC;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check_idle("flush");
    check("flush max_occ", 32'(max_occupancy), 0);

    // Asynchronous reset pulse between edges with three words stored.
    in_valid = 1'b1;
    in_data = 10'h301; step();
    in_data = 10'h302; step();
    in_data = 10'h303; step();
    in_valid = 1'b0;
    check("pre-rst occ", 32'(occupancy), 3);
    #2;
    reset = 1'b1;
    #1;
    check("async rst valid", 32'(out_valid), 0);
    check("async rst occ", 32'(occupancy), 0);
    check("async rst max_occ", 32'(max_occupancy), 0);
    #1;
    reset = 1'b0;
    step();
    check("post-rst still empty", 32'(out_valid), 0);
    in_valid = 1'b1;
    in_data = 10'h3C3;
    step();
    in_valid = 1'b0;
    check("post-rst occ", 32'(occupancy), 1);
    check("post-rst data", 32'(out_data), 32'h3C3);
    check("post-rst max_occ", 32'(max_occupancy), 1);
    out_is_taken = 1'b1;
    step();
    out_is_taken = 1'b0;
    check("post-rst empty", 32'(out_valid), 0);
    check("post-rst no udf", 32'(underflow_error), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
